// File: rtl/fallthrough_fifo_pkg.sv
// Shared types for the fall-through FIFO: the per-cycle operation encoding
// formed from the accepted push/pop pair.
package fallthrough_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fallthrough_fifo_ram.sv
// Register-array storage for the FWFT FIFO: synchronous write port and an
// asynchronous read port so the head entry is visible without a read cycle.
module fwft_ram #(
  parameter int WIDTH     = 72,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // define which entries are valid, and an unreset array maps onto plain
  // registers or distributed RAM instead of a reset fan-out tree.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fallthrough_fifo.sv
// First-word-fall-through FIFO used as the packet-path input elastic buffer.
// Pointers, occupancy counter and flags live here; storage is in fwft_ram.
module fallthrough_fifo
  import fallthrough_fifo_pkg::*;
#(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = (1 << MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CNT_W = MAX_DEPTH_BITS + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_NFULL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_PROG  = CNT_W'(PROG_FULL_THRESHOLD);

  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      push_ok;
  logic                      pop_ok;
  fifo_op_e                  op;

  // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | pop_ok);
  assign op      = fifo_op_e'({push_ok, pop_ok});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Flags depend on registered count only, never on wr_en/rd_en.
  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign nearly_full = (count >= CNT_NFULL);
  assign prog_full   = (count >= CNT_PROG);

  fwft_ram #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (MAX_DEPTH_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

  // Misuse reporting for simulation; ignored by synthesis.
  always @(posedge clk) begin
    if (!reset && wr_en && full && !rd_en) begin
      $warning("fallthrough_fifo: overflow, write dropped");
    end
    if (!reset && rd_en && empty) begin
      $warning("fallthrough_fifo: underflow, read ignored");
    end
  end

endmodule

// File: tb/tb_fallthrough_fifo.sv
// Self-checking bench for fallthrough_fifo (D=4, prog_full at 3) using a
// data scoreboard queue and an occupancy model for the flags.
module tb_fallthrough_fifo;

  localparam int W   = 72;
  localparam int MDB = 2;
  localparam int D   = 4;
  localparam int THR = 3;

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         full;
  logic         nearly_full;
  logic         prog_full;
  logic         empty;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] sb_q[$];
  int           m_count = 0;

  fallthrough_fifo #(
    .WIDTH               (W),
    .MAX_DEPTH_BITS      (MDB),
    .PROG_FULL_THRESHOLD (THR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .nearly_full (nearly_full),
    .prog_full   (prog_full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {empty, full, nearly_full, prog_full} expected for a given occupancy.
  function automatic logic [3:0] exp_flags(input int c);
    return {(c == 0), (c == D), (c >= D - 1), (c >= THR)};
  endfunction

  // One clock of stimulus. Called #1 after a rising edge; returns #1 after
  // the next one. Captures the head before the edge when a pop is accepted.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                      output logic pushed, output logic popped,
                      output logic [W-1:0] exp_head, output logic [W-1:0] got_head);
    popped   = r && (m_count > 0);
    pushed   = w && ((m_count < D) || popped);
    exp_head = '0;
    got_head = dout;
    if (popped) exp_head = sb_q.pop_front();
    if (pushed) sb_q.push_back(d);
    m_count = m_count + (pushed ? 1 : 0) - (popped ? 1 : 0);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic p, q;
    logic [W-1:0] e, g;
    checks++;
    if ({empty, full, nearly_full, prog_full} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_initial flags got=%b exp=1000", {empty, full, nearly_full, prog_full});
    end
    step(1'b1, 1'b0, 72'h11, p, q, e, g);
    step(1'b1, 1'b0, 72'h12, p, q, e, g);
    step(1'b1, 1'b0, 72'h13, p, q, e, g);
    #2 reset = 1'b1;
    #1;
    sb_q.delete();
    m_count = 0;
    checks++;
    if ({empty, full, nearly_full, prog_full} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_async flags got=%b exp=1000", {empty, full, nearly_full, prog_full});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({empty, full, nearly_full, prog_full} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_held flags got=%b exp=1000", {empty, full, nearly_full, prog_full});
    end
    reset = 1'b0;
    step(1'b1, 1'b0, 72'h55, p, q, e, g);
    checks++;
    if (empty !== 1'b0 || dout !== 72'h55) begin
      errors++;
      $display("FAIL reset_first_write empty=%b dout=%h exp empty=0 dout=55", empty, dout);
    end
    step(1'b0, 1'b1, '0, p, q, e, g);
    checks++;
    if (g !== e || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_drain got=%h exp=%h empty=%b", g, e, empty);
    end
  endtask

  task automatic test_single();
    logic p, q;
    logic [W-1:0] e, g;
    step(1'b1, 1'b0, 72'hA1, p, q, e, g);
    checks++;
    if (empty !== 1'b0 || dout !== 72'hA1) begin
      errors++;
      $display("FAIL single_fallthrough empty=%b dout=%h exp empty=0 dout=a1", empty, dout);
    end
    step(1'b0, 1'b1, '0, p, q, e, g);
    checks++;
    if (g !== e || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_pop got=%h exp=%h empty=%b exp_empty=1", g, e, empty);
    end
  endtask

  task automatic test_fill();
    logic p, q;
    logic [W-1:0] e, g;
    for (int i = 1; i <= D + 1; i++) begin
      step(1'b1, 1'b0, W'(i), p, q, e, g);
      checks++;
      if ({empty, full, nearly_full, prog_full} !== exp_flags(m_count)) begin
        errors++;
        $display("FAIL fill_flags write=%0d got=%b exp=%b", i, {empty, full, nearly_full, prog_full},
                 exp_flags(m_count));
      end
    end
    checks++;
    if (dout !== 72'h01 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow_drop dout=%h full=%b exp dout=01 full=1", dout, full);
    end
    for (int i = 1; i <= D; i++) begin
      step(1'b0, 1'b1, '0, p, q, e, g);
      checks++;
      if (g !== e || e !== W'(i)) begin
        errors++;
        $display("FAIL fill_pop_order idx=%0d got=%h exp=%h", i, g, W'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_drained empty=%b exp=1", empty);
    end
  endtask

  task automatic test_full_rw();
    logic p, q;
    logic [W-1:0] e, g;
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i), p, q, e, g);
    step(1'b1, 1'b1, 72'h10, p, q, e, g);
    checks++;
    if (g !== 72'h01 || !p || full !== 1'b1 || dout !== 72'h02) begin
      errors++;
      $display("FAIL full_rw got_head=%h full=%b dout=%h exp head=01 full=1 dout=02", g, full, dout);
    end
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, '0, p, q, e, g);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL full_rw_drain idx=%0d got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if (e !== 72'h10 || empty !== 1'b1) begin
      errors++;
      $display("FAIL full_rw_last last=%h exp=10 empty=%b", e, empty);
    end
  endtask

  task automatic test_underflow();
    logic p, q;
    logic [W-1:0] e, g;
    step(1'b0, 1'b1, '0, p, q, e, g);
    checks++;
    if ({empty, full, nearly_full, prog_full} !== 4'b1000) begin
      errors++;
      $display("FAIL underflow_flags got=%b exp=1000", {empty, full, nearly_full, prog_full});
    end
    step(1'b1, 1'b1, 72'h33, p, q, e, g);
    checks++;
    if (dout !== 72'h33 || {empty, full, nearly_full, prog_full} !== exp_flags(1)) begin
      errors++;
      $display("FAIL empty_rw dout=%h flags=%b exp dout=33 flags=%b", dout,
               {empty, full, nearly_full, prog_full}, exp_flags(1));
    end
    step(1'b0, 1'b1, '0, p, q, e, g);
    checks++;
    if (g !== 72'h33 || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_pop got=%h exp=33 empty=%b", g, empty);
    end
  endtask

  task automatic test_back_to_back();
    logic p, q, w, r;
    logic [W-1:0] e, g;
    int sent = 0, rcvd = 0, drops = 0, cyc = 0;
    while ((sent < 100 || m_count > 0) && cyc < 2000) begin
      w = (sent < 100) && !nearly_full;
      r = (sent >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      step(w, r, W'(32'h1000 + sent), p, q, e, g);
      if (w && !p) drops++;
      if (p) sent++;
      if (q) begin
        rcvd++;
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL stream_data idx=%0d got=%h exp=%h", rcvd, g, e);
        end
      end
      checks++;
      if ({empty, full, nearly_full, prog_full} !== exp_flags(m_count)) begin
        errors++;
        $display("FAIL stream_flags cyc=%0d got=%b exp=%b", cyc, {empty, full, nearly_full, prog_full},
                 exp_flags(m_count));
      end
      cyc++;
    end
    checks++;
    if (cyc >= 2000 || rcvd !== 100 || drops !== 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_end rcvd=%0d drops=%0d empty=%b cycles=%0d exp rcvd=100 drops=0 empty=1",
               rcvd, drops, empty, cyc);
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_rw();
    test_underflow();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
